// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per oversample tick, truncated; never below one clock.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, realigned by restart_i.
module uart_os_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting and a one-deep ready/valid output.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] S0 = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] S1 = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] S2 = OSW'(OVERSAMPLE / 2 + 1);

  if (!(OVERSAMPLE == 8 || OVERSAMPLE == 16) || DATA_BITS < 5 || DATA_BITS > 9 ||
      !(STOP_BITS == 1 || STOP_BITS == 2) || PARITY < 0 || PARITY > 2) begin : g_bad_cfg
    $error("uart_rx_os: illegal parameter combination");
  end

  logic sync1_q, sync2_q, prev_q, fall, restart, tick, dec, bitv;
  rx_state_e state_q, state_d;
  logic [OSW-1:0] os_q, os_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shr_q, shr_d;
  logic [1:0] smp_q, smp_d;
  logic ferr_acc_q, ferr_acc_d, fe_frame, frame_done, perr_frame, hs;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall    = prev_q & ~sync2_q;
  assign restart = (state_q == ST_IDLE) && fall;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // The third vote sample is the live synchronised value, so the decision lands on its tick.
  assign bitv = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);

  always_comb begin
    os_d  = os_q;
    smp_d = smp_q;
    dec   = 1'b0;
    if (restart) begin
      os_d = '0;
    end else if (tick && state_q != ST_IDLE) begin
      os_d = os_q + 1'b1;
      if (os_q == S0) smp_d[0] = sync2_q;
      if (os_q == S1) smp_d[1] = sync2_q;
      if (os_q == S2) dec = 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_acc_q, perr_acc_d;
  assign perr_frame = perr_acc_q;
`else
  assign perr_frame = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shr_d      = shr_q;
    ferr_acc_d = ferr_acc_q;
    frame_done = 1'b0;
    fe_frame   = ferr_acc_q | ~bitv;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_acc_d = perr_acc_q;
`endif
    case (state_q)
      ST_IDLE: if (restart) state_d = ST_START;
      ST_START: if (dec) begin
        bit_d      = '0;
        ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = 1'b0;
        perr_acc_d = 1'b0;
`endif
        state_d    = bitv ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (dec) begin
        shr_d = {bitv, shr_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
        par_d = par_q ^ bitv;
`endif
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d = '0;
`ifdef UART_RX_PARITY_EN
          state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
`else
          state_d = ST_STOP;
`endif
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PAR: if (dec) begin
        perr_acc_d = (PARITY == PAR_ODD) ? ~(par_q ^ bitv) : (par_q ^ bitv);
        state_d    = ST_STOP;
      end
`endif
      ST_STOP: if (dec) begin
        if (bit_q == 4'(STOP_BITS - 1)) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          bit_d      = bit_q + 4'd1;
          ferr_acc_d = fe_frame;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A frame finishing on a handshake cycle takes the freed slot instead of overrunning.
  always_comb begin
    hs      = valid_q & m_ready;
    valid_d = valid_q & ~hs;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (frame_done) begin
      if (valid_q && !hs) begin
        ovr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shr_q;
        pe_d    = perr_frame;
        fe_d    = fe_frame;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      os_q       <= '0;
      bit_q      <= '0;
      shr_q      <= '0;
      smp_q      <= '0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      shr_q      <= shr_d;
      smp_q      <= smp_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q      <= 1'b0;
      perr_acc_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      perr_acc_q <= perr_acc_d;
    end
  end
`endif

  assign m_data     = data_q;
  assign m_valid    = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level model predicting delivery cycles, plus directed literal checks.
module tb_uart_rx_os;

  localparam int CLK_HZ = 7_372_800;  // DIV = 4 at 115200 baud, 16x
  localparam int OS     = 16;
  localparam int DIV    = 4;
  localparam int BIT    = DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rx0 = 1'b1, rx1 = 1'b1, m_ready = 1'b1;
  logic [7:0] m_data0;
  logic [6:0] m_data1;
  logic mv0, pe0, fe0, ov0, bz0, mv1, pe1, fe1, ov1, bz1;

  uart_rx_os #(.CLK_HZ(CLK_HZ)) dut0 (
    .clk(clk), .rst(rst), .rx_in(rx0), .m_data(m_data0), .m_valid(mv0), .m_ready(m_ready),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(bz0));

  uart_rx_os #(.CLK_HZ(CLK_HZ), .DATA_BITS(7), .PARITY(2)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx1), .m_data(m_data1), .m_valid(mv1), .m_ready(m_ready),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(bz1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Line fall to m_valid: 2 sync flops + edge flop, then the tick that ends the last stop vote.
  function automatic int lat(input int nb);
    return 3 + ((nb - 1) * OS + OS / 2 + 2) * DIV;
  endfunction

  typedef struct {
    int d;
    int dc;
    logic [8:0] data;
    bit pe;
    bit fe;
  } exp_t;
  exp_t pq[$];

  bit ev[2], epe[2], efe[2], eov[2], pv[2];
  logic [8:0] ed[2], ld[2];
  bit lpe[2], lfe[2];
  int nrise[2], rise_cyc[2], novr[2];
  bit rdy_prev = 1'b0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : per_dut
      bit hs, done, av, ape, afe, aov, abz;
      logic [8:0] ad;
      exp_t e;
      hs = ev[d] && rdy_prev;
      eov[d] = 1'b0;
      done = 1'b0;
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].d == d && pq[i].dc == cyc) begin
          e = pq[i];
          done = 1'b1;
          pq.delete(i);
          break;
        end
      if (rst) begin
        ev[d] = 1'b0; ed[d] = '0; epe[d] = 1'b0; efe[d] = 1'b0;
      end else if (done) begin
        if (ev[d] && !hs) eov[d] = 1'b1;
        else begin
          ev[d] = 1'b1; ed[d] = e.data; epe[d] = e.pe; efe[d] = e.fe;
        end
      end else if (hs) ev[d] = 1'b0;
      if (d == 0) begin
        av = mv0; ad = {1'b0, m_data0}; ape = pe0; afe = fe0; aov = ov0; abz = bz0;
      end else begin
        av = mv1; ad = {2'b0, m_data1}; ape = pe1; afe = fe1; aov = ov1; abz = bz1;
      end
      chk($sformatf("dut%0d m_valid", d), 32'(av), 32'(ev[d]));
      chk($sformatf("dut%0d overrun", d), 32'(aov), 32'(eov[d]));
      if (rst) chk($sformatf("dut%0d busy in reset", d), 32'(abz), 32'd0);
      if (ev[d]) begin
        chk($sformatf("dut%0d m_data", d), 32'(ad), 32'(ed[d]));
        chk($sformatf("dut%0d parity_err", d), 32'(ape), 32'(epe[d]));
        chk($sformatf("dut%0d frame_err", d), 32'(afe), 32'(efe[d]));
      end
      if (av && !pv[d]) begin
        nrise[d]++; rise_cyc[d] = cyc; ld[d] = ad; lpe[d] = ape; lfe[d] = afe;
      end
      pv[d] = av;
      if (aov) novr[d]++;
    end
    if (rst) pq.delete();
    rdy_prev = m_ready;
  end

  task automatic drive(input int d, input logic v, input int n);
    if (d == 0) rx0 = v; else rx1 = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Sends one frame (even parity bit on dut1 when parity is built) followed by one idle bit.
  task automatic send(input int d, input logic [8:0] data, input bit stopv, input bit flip);
    int nd, nb;
    bit hp, pb;
    logic [15:0] fr;
    logic [8:0] dm;
    exp_t e;
    nd = (d == 0) ? 8 : 7;
    hp = (d == 1) && PEN;
    dm = '0; pb = flip; fr = '0; nb = 0;
    fr[nb] = 1'b0; nb++;
    for (int i = 0; i < nd; i++) begin
      dm[i] = data[i]; pb ^= data[i]; fr[nb] = data[i]; nb++;
    end
    if (hp) begin fr[nb] = pb; nb++; end
    fr[nb] = stopv; nb++;
    e.d = d; e.dc = cyc + lat(nb); e.data = dm;
    e.pe = hp && ((^dm) ^ pb);
    e.fe = !stopv;
    pq.push_back(e);
    for (int i = 0; i < nb; i++) drive(d, fr[i], BIT);
    drive(d, 1'b1, BIT);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: cycle %0d exceeded limit 90000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, dc;
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset m_data", 32'(m_data0), 32'h0);
    chk("reset m_valid", 32'(mv0), 32'h0);
    chk("reset busy", 32'(bz0), 32'h0);
    chk("reset overrun", 32'(ov0), 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Clean 0xA5: exact delivery latency
    c0 = cyc;
    send(0, 9'h0A5, 1'b1, 1'b0);
    chk("A5 latency", 32'(rise_cyc[0] - c0), 32'd619);
    chk("A5 data", 32'(ld[0]), 32'h0A5);
    chk("A5 parity_err", 32'(lpe[0]), 32'h0);
    chk("A5 frame_err", 32'(lfe[0]), 32'h0);

    // Low stop bit, then a clean frame
    send(0, 9'h03C, 1'b0, 1'b0);
    chk("3C data", 32'(ld[0]), 32'h03C);
    chk("3C frame_err", 32'(lfe[0]), 32'h1);
    send(0, 9'h011, 1'b1, 1'b0);
    chk("11 data", 32'(ld[0]), 32'h011);
    chk("11 frame_err", 32'(lfe[0]), 32'h0);

    // Overrun while held, then a completion coinciding with a handshake
    m_ready = 1'b0;
    n = novr[0];
    send(0, 9'h001, 1'b1, 1'b0);
    send(0, 9'h002, 1'b1, 1'b0);
    chk("overrun pulses", 32'(novr[0] - n), 32'd1);
    chk("held data", 32'(m_data0), 32'h01);
    chk("held valid", 32'(mv0), 32'h1);
    fork
      send(0, 9'h003, 1'b1, 1'b0);
      begin
        dc = cyc + lat(10);
        while (cyc < dc - 1) begin @(posedge clk); #1; end
        #1 m_ready = 1'b1;
      end
    join
    chk("same-cycle no overrun", 32'(novr[0] - n), 32'd1);
    chk("valid cleared after handshake", 32'(mv0), 32'h0);
    chk("same-cycle data", 32'(m_data0), 32'h03);

    // 0.3-bit glitch is a false start
    n = nrise[0];
    drive(0, 1'b0, 10);
    chk("glitch busy", 32'(bz0), 32'h1);
    drive(0, 1'b0, 9);
    drive(0, 1'b1, BIT - 19);
    chk("glitch busy released", 32'(bz0), 32'h0);
    drive(0, 1'b1, BIT);
    chk("glitch no frame", 32'(nrise[0] - n), 32'd0);

    // Reset during data bit 4 of 0xFF discards it
    n = nrise[0];
    fork
      begin
        drive(0, 1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(0, 1'b1, BIT);
        drive(0, 1'b1, 2 * BIT);
      end
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    chk("aborted frame dropped", 32'(nrise[0] - n), 32'd0);
    send(0, 9'h05A, 1'b1, 1'b0);
    chk("after reset count", 32'(nrise[0] - n), 32'd1);
    chk("after reset data", 32'(ld[0]), 32'h05A);

    // 7-bit even parity: good then flipped parity bit
    send(1, 9'h035, 1'b1, 1'b0);
    chk("par good data", 32'(ld[1]), 32'h035);
    chk("par good parity_err", 32'(lpe[1]), 32'h0);
    send(1, 9'h035, 1'b1, 1'b1);
    chk("par bad data", 32'(ld[1]), 32'h035);
    chk("par bad parity_err", 32'(lpe[1]), 32'(PEN));
    chk("par bad frame_err", 32'(lfe[1]), 32'h0);
    chk("par frames", 32'(nrise[1]), 32'd2);

    repeat (4) @(posedge clk);
    chk("pending drained", 32'(pq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
